stream_nn_scaler: RTL and testbench
===================================

# stream_nn_scaler

Parametrised nearest-neighbour video stream scaler that up- or down-scales a raster frame independently in X and Y using Q(SCALE_INT).(SCALE_FRAC) step factors. It sits in the Video_Scaler pipeline between a pixel source and a paced consumer, using the same dIn/nextDin and dOut/nextDout request handshakes as the bilinear stream scaler. It generalises channel count, pixel width, scale-factor format and line-buffer depth. It runs from a two-line ping-pong buffer, so it needs no frame store.

## Interface
- DATA_WIDTH, 8, bits per channel
- CHANNELS, 3, channels per pixel; pixel word = DATA_WIDTH*CHANNELS
- X_RES_WIDTH, 11, width of X resolution/count fields
- Y_RES_WIDTH, 11, width of Y resolution/count fields
- SCALE_INT, 4, integer bits of scale factors
- SCALE_FRAC, 14, fractional bits of scale factors
- MAX_LINE, 2048, pixel depth of each line buffer; must be ≥ inputXRes+1
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- dIn  in  DATA_WIDTH*CHANNELS  input pixel
- dInValid  in  1  dIn holds a valid pixel
- nextDin  out  1  scaler accepts dIn this cycle
- dOut  out  DATA_WIDTH*CHANNELS  output pixel
- dOutValid  out  1  dOut valid this cycle
- nextDout  in  1  consumer requests pixels
- inputXRes, inputYRes  in  X_RES_WIDTH / Y_RES_WIDTH  input width−1 / height−1
- outputXRes, outputYRes  in  X_RES_WIDTH / Y_RES_WIDTH  output width−1 / height−1
- xScale, yScale  in  SCALE_INT+SCALE_FRAC  source step per output pixel/line (1.0 = 1<<SCALE_FRAC)
- frameDone  out  1  one-cycle pulse when the frame is complete

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on start. Entering RUN clears the write counters wX and wY, the output counters oX and oY, and the accumulators xAcc and yAcc. start is ignored outside IDLE.
- Control inputs are sampled on start and held internally for the frame.
- Writer:
  - Pixel transfer happens on a rising edge with dInValid && nextDin.
  - Each transferred pixel is written to buf[wY[0]][wX]. wX wraps at inputXRes, then wY increments.
  - nextDin = RUN/DRAIN && wY ≤ inputYRes && (wY < srcY+2 || DRAIN). It is combinational from registers only and has no path from dInValid.
- Source line: srcY = min(yAcc >> SCALE_FRAC, inputYRes).
- Reader:
  - An output line is available when wY > srcY, i.e. line srcY is fully written.
  - Each cycle with nextDout && line available && oY ≤ outputYRes, the reader reads buf[srcY[0]][min(xAcc >> SCALE_FRAC, inputXRes)] and adds xScale to xAcc.
  - When oX reaches outputXRes: oX ← 0, xAcc ← 0, yAcc += yScale, oY++.
- Downscale: input lines skipped by srcY are still accepted and overwritten.
- Upscale: line srcY is re-read while yAcc stays within it.
- Conflict-free: the writer only writes line srcY+1 while line srcY is read. Those lines occupy opposite buffers.
- When oY passes outputYRes, go RUN → DRAIN. DRAIN accepts and discards remaining input lines.
- DRAIN → IDLE once wY > inputYRes, pulsing frameDone on the transition.
- Accumulators are unsigned. Widths: xAcc is X_RES_WIDTH+SCALE_FRAC bits, yAcc is Y_RES_WIDTH+SCALE_FRAC bits. They saturate instead of wrapping.

## Timing
- Reset values: nextDin=0, dOutValid=0, dOut=0, frameDone=0, state=IDLE.
- Reset asserted mid-frame aborts immediately. No frameDone is produced, buffer contents are don't-care, and a new start is required.
- Read latency: dOutValid rises 1 cycle after the qualifying nextDout cycle, with registered RAM output.
- After nextDout falls, at most one further pixel appears. The consumer must take every dOutValid pixel, since there is no output backpressure.
- A start pulse followed by immediate valid input makes nextDin high the cycle after start.
- The first dOut appears inputXRes+1 accepted pixels plus 2 cycles after nextDout rises.
- Simultaneous last-input write and first read of that line are allowed. Availability is evaluated on registered wY, so the read happens one cycle later.
- Full-rate operation: 1 pixel/cycle in and 1 pixel/cycle out concurrently.

## Configuration
- STREAM_NN_SCALER_HMIRROR_EN:
  - Defined: the read address is inputXRes − min(xAcc >> SCALE_FRAC, inputXRes), so every output line is horizontally mirrored.
  - Undefined: normal left-to-right order.
  - Ports and latency are identical in both builds.

## Test plan
- Identity: 4×4 in, 4×4 out, xScale=yScale=0x4000, nextDout=1 → 16 outputs equal the input in raster order; frameDone pulses once.
- 2× up: 4×4 → 8×8, scale=0x2000 → each pixel repeated 2× in X; each source line emitted twice in order 0,0,1,1,2,2,3,3.
- 2× down: 8×8 → 4×4, scale=0x8000 → output is source pixels (0,2,4,6)×(0,2,4,6); all 64 inputs accepted; frameDone after the last input.
- Clamp: 4-wide in, 6-wide out, xScale=0x4000 → X sources 0,1,2,3,3,3.
- Pacing: 8×8 → 8×8 identity, nextDout toggled 4 cycles high / 2 low → 64 outputs with no loss or duplication; ≤1 pixel after each nextDout fall.
- Reset mid-frame: assert rst_n low after 10 outputs → all outputs 0 next cycle; restart with start produces a correct full frame. Repeat identity with HMIRROR_EN → each line reversed.

Source files
------------

// File: rtl/stream_nn_scaler.sv
// Nearest-neighbour stream scaler: two-line ping-pong buffer, Q(SCALE_INT).(SCALE_FRAC) steps.
// Define STREAM_NN_SCALER_HMIRROR_EN to mirror every output line horizontally.
module stream_nn_scaler #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 3,
    parameter int X_RES_WIDTH = 11,
    parameter int Y_RES_WIDTH = 11,
    parameter int SCALE_INT   = 4,
    parameter int SCALE_FRAC  = 14,
    parameter int MAX_LINE    = 2048
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DATA_WIDTH*CHANNELS-1:0]   dIn,
    input  logic                             dInValid,
    output logic                             nextDin,
    output logic [DATA_WIDTH*CHANNELS-1:0]   dOut,
    output logic                             dOutValid,
    input  logic                             nextDout,
    input  logic [X_RES_WIDTH-1:0]           inputXRes,
    input  logic [Y_RES_WIDTH-1:0]           inputYRes,
    input  logic [X_RES_WIDTH-1:0]           outputXRes,
    input  logic [Y_RES_WIDTH-1:0]           outputYRes,
    input  logic [SCALE_INT+SCALE_FRAC-1:0]  xScale,
    input  logic [SCALE_INT+SCALE_FRAC-1:0]  yScale,
    output logic                             frameDone
);

    localparam int PIX_W   = DATA_WIDTH * CHANNELS;
    localparam int SCALE_W = SCALE_INT + SCALE_FRAC;
    localparam int XACC_W  = X_RES_WIDTH + SCALE_FRAC;
    localparam int YACC_W  = Y_RES_WIDTH + SCALE_FRAC;
    localparam int XSUM_W  = XACC_W + 1;
    localparam int YSUM_W  = YACC_W + 1;
    localparam int ADDR_W  = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam int WY_W    = Y_RES_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                 state_q;

    logic [X_RES_WIDTH-1:0] in_xres_q;
    logic [Y_RES_WIDTH-1:0] in_yres_q;
    logic [X_RES_WIDTH-1:0] out_xres_q;
    logic [Y_RES_WIDTH-1:0] out_yres_q;
    logic [SCALE_W-1:0]     xscale_q;
    logic [SCALE_W-1:0]     yscale_q;

    logic [X_RES_WIDTH-1:0] wx_q;
    logic [WY_W-1:0]        wy_q;
    logic [X_RES_WIDTH-1:0] ox_q;
    logic [WY_W-1:0]        oy_q;
    logic [XACC_W-1:0]      xacc_q;
    logic [YACC_W-1:0]      yacc_q;

    logic [PIX_W-1:0]       dout_q;
    logic                   dout_valid_q;
    logic                   frame_done_q;

    logic [PIX_W-1:0]       line_mem [2][MAX_LINE];

    logic [Y_RES_WIDTH-1:0] acc_y_int;
    logic [Y_RES_WIDTH-1:0] src_y;
    logic [X_RES_WIDTH-1:0] acc_x_int;
    logic [X_RES_WIDTH-1:0] src_x;
    logic [X_RES_WIDTH-1:0] rd_x;
    logic [XSUM_W-1:0]      xacc_sum;
    logic [YSUM_W-1:0]      yacc_sum;
    logic [XACC_W-1:0]      xacc_d;
    logic [YACC_W-1:0]      yacc_d;
    logic                   running;
    logic                   line_avail;
    logic                   wr_en;
    logic                   rd_en;

    // Integer parts of the accumulators, clamped to the last valid source line/pixel.
    assign acc_y_int = yacc_q[YACC_W-1:SCALE_FRAC];
    assign src_y     = (acc_y_int > in_yres_q) ? in_yres_q : acc_y_int;
    assign acc_x_int = xacc_q[XACC_W-1:SCALE_FRAC];
    assign src_x     = (acc_x_int > in_xres_q) ? in_xres_q : acc_x_int;

`ifdef STREAM_NN_SCALER_HMIRROR_EN
    assign rd_x = in_xres_q - src_x;
`else
    assign rd_x = src_x;
`endif

    // Saturating accumulator steps: a carry out pins the accumulator at all ones.
    assign xacc_sum = {1'b0, xacc_q} + XSUM_W'(xscale_q);
    assign yacc_sum = {1'b0, yacc_q} + YSUM_W'(yscale_q);
    assign xacc_d   = xacc_sum[XACC_W] ? '1 : xacc_sum[XACC_W-1:0];
    assign yacc_d   = yacc_sum[YACC_W] ? '1 : yacc_sum[YACC_W-1:0];

    assign running    = (state_q == RUN) || (state_q == DRAIN);
    assign line_avail = wy_q > {1'b0, src_y};

    // The writer may run at most one line ahead of the line being read, so the two
    // live lines always sit in opposite halves of the ping-pong buffer.
    assign nextDin = running
                   && (wy_q <= {1'b0, in_yres_q})
                   && ((wy_q < ({1'b0, src_y} + WY_W'(2))) || (state_q == DRAIN));

    assign wr_en = dInValid && nextDin;
    assign rd_en = (state_q == RUN) && nextDout && line_avail
                 && (oy_q <= {1'b0, out_yres_q});

    // NOTE: line buffers carry no reset; their contents are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wy_q[0]][ADDR_W'(wx_q)] <= dIn;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_xres_q    <= '0;
            in_yres_q    <= '0;
            out_xres_q   <= '0;
            out_yres_q   <= '0;
            xscale_q     <= '0;
            yscale_q     <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            xacc_q       <= '0;
            yacc_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            dout_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        in_xres_q  <= inputXRes;
                        in_yres_q  <= inputYRes;
                        out_xres_q <= outputXRes;
                        out_yres_q <= outputYRes;
                        xscale_q   <= xScale;
                        yscale_q   <= yScale;
                        wx_q       <= '0;
                        wy_q       <= '0;
                        ox_q       <= '0;
                        oy_q       <= '0;
                        xacc_q     <= '0;
                        yacc_q     <= '0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (oy_q > {1'b0, out_yres_q}) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wy_q > {1'b0, in_yres_q}) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (wr_en) begin
                if (wx_q == in_xres_q) begin
                    wx_q <= '0;
                    wy_q <= wy_q + WY_W'(1);
                end else begin
                    wx_q <= wx_q + X_RES_WIDTH'(1);
                end
            end

            if (rd_en) begin
                dout_q       <= line_mem[src_y[0]][ADDR_W'(rd_x)];
                dout_valid_q <= 1'b1;
                if (ox_q == out_xres_q) begin
                    ox_q   <= '0;
                    xacc_q <= '0;
                    yacc_q <= yacc_d;
                    oy_q   <= oy_q + WY_W'(1);
                end else begin
                    ox_q   <= ox_q + X_RES_WIDTH'(1);
                    xacc_q <= xacc_d;
                end
            end
        end
    end

    assign dOut      = dout_q;
    assign dOutValid = dout_valid_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_stream_nn_scaler.sv
// Bench for stream_nn_scaler: a frame-level model of nearest-neighbour sampling is compared
// against every output pixel, plus hand-computed pixel literals and frame-end checks.
module tb_stream_nn_scaler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] dIn = '0;
    logic        dInValid = 1'b0;
    logic        nextDin;
    logic [23:0] dOut;
    logic        dOutValid;
    logic        nextDout = 1'b0;
    logic [10:0] inputXRes = '0;
    logic [10:0] inputYRes = '0;
    logic [10:0] outputXRes = '0;
    logic [10:0] outputYRes = '0;
    logic [17:0] xScale = '0;
    logic [17:0] yScale = '0;
    logic        frameDone;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];

    stream_nn_scaler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dIn        (dIn),
        .dInValid   (dInValid),
        .nextDin    (nextDin),
        .dOut       (dOut),
        .dOutValid  (dOutValid),
        .nextDout   (nextDout),
        .inputXRes  (inputXRes),
        .inputYRes  (inputYRes),
        .outputXRes (outputXRes),
        .outputYRes (outputYRes),
        .xScale     (xScale),
        .yScale     (yScale),
        .frameDone  (frameDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pixel value tags the frame, row and column so any misplaced pixel is visible.
    function automatic logic [23:0] pix(input int tag, input int x, input int y);
        logic [7:0] t, xx, yy;
        t  = tag[7:0];
        xx = x[7:0];
        yy = y[7:0];
        return {t, yy, xx};
    endfunction

    // Runs one frame. pace=1 toggles nextDout 4 high / 2 low; abort_after>0 resets the
    // DUT once that many outputs have been seen.
    task automatic run_frame(input int ixr, input int iyr, input int oxr, input int oyr,
                             input int xs, input int ys, input int tag,
                             input int pace, input int abort_after);
        int total, in_idx, n_out, n_done, cyc, low_valids, sx, sy;
        bit pending, finished, aborted, nd_cur;
        logic [31:0] xs_v, ys_v;

        exp_q.delete();
        got_q.delete();
        for (int oy = 0; oy <= oyr; oy++) begin
            for (int ox = 0; ox <= oxr; ox++) begin
                sy = (oy * ys) / 16384;
                if (sy > iyr) sy = iyr;
                sx = (ox * xs) / 16384;
                if (sx > ixr) sx = ixr;
`ifdef STREAM_NN_SCALER_HMIRROR_EN
                sx = ixr - sx;
`endif
                exp_q.push_back(pix(tag, sx, sy));
            end
        end

        total = (ixr + 1) * (iyr + 1);
        in_idx = 0; n_out = 0; n_done = 0; cyc = 0; low_valids = 0;
        pending = 0; finished = 0; aborted = 0;
        xs_v = xs;
        ys_v = ys;

        @(negedge clk);
        inputXRes  = ixr[10:0];
        inputYRes  = iyr[10:0];
        outputXRes = oxr[10:0];
        outputYRes = oyr[10:0];
        xScale     = xs_v[17:0];
        yScale     = ys_v[17:0];
        nextDout   = 1'b1;
        start      = 1'b1;

        while (!finished && !aborted && cyc < 4000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            nd_cur = nextDout;
            if (pending) in_idx++;

            if (dOutValid) begin
                got_q.push_back(dOut);
                if (n_out < exp_q.size())
                    check($sformatf("frame%0d_pix%0d", tag, n_out), dOut, exp_q[n_out]);
                if (!nd_cur) begin
                    low_valids++;
                    check($sformatf("frame%0d_tail_after_fall", tag), low_valids <= 1, 1);
                end
                n_out++;
            end
            if (nd_cur) low_valids = 0;

            if (frameDone) begin
                n_done++;
                check($sformatf("frame%0d_inputs_at_done", tag), in_idx, total);
                finished = 1;
            end

            if (abort_after > 0 && n_out >= abort_after) begin
                rst_n = 1'b0;
                aborted = 1;
            end

            dInValid = (in_idx < total);
            dIn      = pix(tag, in_idx % (ixr + 1), in_idx / (ixr + 1));
            pending  = nextDin && dInValid;
            nextDout = pace ? ((cyc % 6) < 4) : 1'b1;
        end

        dInValid = 1'b0;
        nextDout = 1'b0;

        if (aborted) begin
            @(negedge clk);
            check("abort_dout_zero", dOut, 0);
            check("abort_valid_low", dOutValid, 0);
            check("abort_nextdin_low", nextDin, 0);
            check("abort_no_done", frameDone, 0);
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end

        repeat (3) begin
            @(negedge clk);
            if (frameDone) n_done++;
            if (dOutValid) got_q.push_back(dOut);
        end
        check($sformatf("frame%0d_finished", tag), finished, 1);
        check($sformatf("frame%0d_done_pulses", tag), n_done, 1);
        check($sformatf("frame%0d_out_count", tag), got_q.size(), exp_q.size());
        check($sformatf("frame%0d_in_count", tag), in_idx, total);
        if (!finished) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_nextdin", nextDin, 0);
        check("reset_valid", dOutValid, 0);
        check("reset_dout", dOut, 0);
        check("reset_done", frameDone, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_nextdin", nextDin, 0);

        // Identity 4x4.
        run_frame(3, 3, 3, 3, 'h4000, 'h4000, 1, 0, 0);
`ifdef STREAM_NN_SCALER_HMIRROR_EN
        check("ident_lit6", got_q[6], 24'h010101);
        check("ident_lit0", got_q[0], 24'h010003);
`else
        check("ident_lit6", got_q[6], 24'h010102);
        check("ident_lit0", got_q[0], 24'h010000);
`endif

        // 2x upscale 4x4 -> 8x8.
        run_frame(3, 3, 7, 7, 'h2000, 'h2000, 2, 0, 0);
`ifdef STREAM_NN_SCALER_HMIRROR_EN
        check("up_lit9", got_q[9], 24'h020003);
        check("up_lit27", got_q[27], 24'h020102);
`else
        check("up_lit9", got_q[9], 24'h020000);
        check("up_lit27", got_q[27], 24'h020101);
`endif

        // 2x downscale 8x8 -> 4x4.
        run_frame(7, 7, 3, 3, 'h8000, 'h8000, 3, 0, 0);
`ifdef STREAM_NN_SCALER_HMIRROR_EN
        check("down_lit5", got_q[5], 24'h030205);
        check("down_lit15", got_q[15], 24'h030601);
`else
        check("down_lit5", got_q[5], 24'h030202);
        check("down_lit15", got_q[15], 24'h030606);
`endif

        // Clamp: 4 wide in, 6 wide out, two lines.
        run_frame(3, 1, 5, 1, 'h4000, 'h4000, 4, 0, 0);
`ifdef STREAM_NN_SCALER_HMIRROR_EN
        check("clamp_lit5", got_q[5], 24'h040000);
        check("clamp_lit10", got_q[10], 24'h040100);
`else
        check("clamp_lit5", got_q[5], 24'h040003);
        check("clamp_lit10", got_q[10], 24'h040103);
`endif

        // Paced identity 8x8.
        run_frame(7, 7, 7, 7, 'h4000, 'h4000, 5, 1, 0);

        // Reset mid-frame, then a clean frame.
        run_frame(7, 7, 7, 7, 'h4000, 'h4000, 6, 0, 10);
        run_frame(3, 3, 3, 3, 'h4000, 'h4000, 7, 0, 0);
`ifdef STREAM_NN_SCALER_HMIRROR_EN
        check("restart_lit15", got_q[15], 24'h070300);
`else
        check("restart_lit15", got_q[15], 24'h070303);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
